// File: rtl/multicycle_ctrl_fsm.sv
// Main control unit for the RV32I multicycle core.
// Moore sequencer for the shared-ALU datapath, plus the ALU decoder and the
// immediate-format decoder. Only ir_write/pc_write in FETCH and pc_write in
// BEQ look at live inputs (mem_ready, zero); everything else is a pure
// function of the state register.
module multicycle_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Internal ALU operation class handed to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     st;
  logic [1:0] alu_op;
  logic       pcw, irw, mw, rw;

  assign state = st;

  // State register and next-state sequencing; unused codes fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= state_t'(RESET_STATE);
    end else begin
      case (st)
        FETCH:    if (mem_ready) st <= DECODE;
        DECODE: begin
          case (op)
            7'b0000011, 7'b0100011: st <= MEMADR;
            7'b0110011:             st <= EXECR;
            7'b0010011:             st <= EXECI;
            7'b1101111:             st <= JAL;
            7'b1100011:             st <= BEQ;
            default:                st <= TRAP;
          endcase
        end
        MEMADR:   st <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) st <= MEMWB;
        MEMWB:    st <= FETCH;
        MEMWRITE: if (mem_ready) st <= FETCH;
        EXECR:    st <= ALUWB;
        EXECI:    st <= ALUWB;
        ALUWB:    st <= FETCH;
        JAL:      st <= ALUWB;
        BEQ:      st <= FETCH;
        TRAP:     st <= TRAP;
        default:  st <= FETCH;
      endcase
    end
  end

  // Per-state datapath controls; enables are forced low while reset is held
  // so an in-flight write strobe drops without waiting for a clock.
  always_comb begin
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (st)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw        = mem_ready;
        pcw        = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        rw         = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw      = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB:    rw = 1'b1;
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw       = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        pcw       = zero;
      end
      TRAP:     illegal = 1'b1;
      default: ;
    endcase
    pc_write  = pcw & ~reset;
    ir_write  = irw & ~reset;
    mem_write = mw  & ~reset;
    reg_write = rw  & ~reset;
  end

  // ALU decoder: funct3 selects the op; sub only for R-type with funct7b5.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format from opcode; held at 00 in the unused state codes.
  always_comb begin
    imm_src = 2'b00;
    if (st <= TRAP) begin
      case (op)
        7'b0100011: imm_src = 2'b01;
        7'b1100011: imm_src = 2'b10;
        7'b1101111: imm_src = 2'b11;
        default:    imm_src = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each scenario queues one
// expected output vector per cycle together with that cycle's mem_ready/zero,
// then replays the queue: inputs change on the falling edge and outputs are
// sampled 1 ns later, so each entry sees exactly one rising edge before it.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    logic [1:0] is;
    logic       rw, il;
  } obs_t;

  typedef struct {
    logic mr;
    logic z;
    obs_t e;
  } item_t;

  item_t sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  obs_t  obs;

  assign obs = {state, pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal};

  multicycle_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Expected vectors, one builder per state, written straight from the state table.
  function automatic obs_t mk(logic [3:0] st, logic pcw, logic adr, logic mw, logic irw,
                              logic [1:0] rs, logic [1:0] sa, logic [1:0] sbs,
                              logic [2:0] ac, logic [1:0] is, logic rw, logic il);
    mk = {st, pcw, adr, mw, irw, rs, sa, sbs, ac, is, rw, il};
  endfunction
  function automatic obs_t e_fetch(logic mr, logic [1:0] is);
    e_fetch = mk(4'd0, mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_dec(logic [1:0] is);
    e_dec = mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_memadr(logic [1:0] is);
    e_memadr = mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_memrd(logic [1:0] is);
    e_memrd = mk(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_memwb(logic [1:0] is);
    e_memwb = mk(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, is, 1, 0);
  endfunction
  function automatic obs_t e_memwr(logic [1:0] is);
    e_memwr = mk(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_execr(logic [2:0] ac, logic [1:0] is);
    e_execr = mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, is, 0, 0);
  endfunction
  function automatic obs_t e_aluwb(logic [1:0] is);
    e_aluwb = mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, is, 1, 0);
  endfunction
  function automatic obs_t e_execi(logic [2:0] ac, logic [1:0] is);
    e_execi = mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ac, is, 0, 0);
  endfunction
  function automatic obs_t e_jal(logic [1:0] is);
    e_jal = mk(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, is, 0, 0);
  endfunction
  function automatic obs_t e_beq(logic z, logic [1:0] is);
    e_beq = mk(4'd10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, is, 0, 0);
  endfunction
  function automatic obs_t e_trap(logic [1:0] is);
    e_trap = mk(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, is, 0, 1);
  endfunction
  // Reset: FETCH selects with every enable low, whatever mem_ready says.
  function automatic obs_t e_rst(logic [1:0] is);
    e_rst = mk(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, is, 0, 0);
  endfunction

  task automatic push(input logic mr, input logic z, input obs_t e);
    item_t it;
    it.mr = mr; it.z = z; it.e = e;
    sb.push_back(it);
  endtask

  task automatic test_reset();
    item_t it;
    push(1, 0, e_rst(2'b00));
    push(1, 1, e_rst(2'b00));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
    @(negedge clk); mem_ready = 0; reset = 0;
  endtask

  task automatic test_rtype();
    item_t       it;
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
    logic        f7s [6] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
    logic [2:0]  acs [6] = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};
    op = 7'b0110011;
    for (int v = 0; v < 6; v++) begin
      funct3 = f3s[v]; funct7b5 = f7s[v];
      push(1, 0, e_fetch(1, 2'b00));
      push(1, 0, e_dec(2'b00));
      push(1, 0, e_execr(acs[v], 2'b00));
      push(1, 0, e_aluwb(2'b00));
      for (int c = 0; sb.size() != 0; c++) begin
        it = sb.pop_front();
        @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
        n_chk++;
        if (obs !== it.e) begin
          n_fail++;
          $display("FAIL rtype v%0d cyc%0d: got %h want %h", v, c, obs, it.e);
        end
      end
    end
  endtask

  task automatic test_itype();
    item_t it;
    // funct7b5 set on addi must not turn it into sub; andi decodes to and.
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    push(1, 0, e_fetch(1, 2'b00));
    push(1, 0, e_dec(2'b00));
    push(1, 0, e_execi(3'b000, 2'b00));
    push(1, 0, e_aluwb(2'b00));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL addi cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
    funct3 = 3'b111;
    push(1, 0, e_fetch(1, 2'b00));
    push(1, 0, e_dec(2'b00));
    push(1, 0, e_execi(3'b010, 2'b00));
    push(1, 0, e_aluwb(2'b00));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL andi cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
  endtask

  task automatic test_lw_stall();
    item_t it;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    push(0, 0, e_fetch(0, 2'b00));
    push(0, 0, e_fetch(0, 2'b00));
    push(1, 0, e_fetch(1, 2'b00));
    push(0, 0, e_dec(2'b00));
    push(0, 0, e_memadr(2'b00));
    push(0, 0, e_memrd(2'b00));
    push(1, 0, e_memrd(2'b00));
    push(0, 0, e_memwb(2'b00));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL lw cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
  endtask

  task automatic test_sw();
    item_t it;
    op = 7'b0100011; funct3 = 3'b010;
    push(1, 0, e_fetch(1, 2'b01));
    push(0, 0, e_dec(2'b01));
    push(0, 0, e_memadr(2'b01));
    push(0, 0, e_memwr(2'b01));
    push(0, 0, e_memwr(2'b01));
    push(1, 0, e_memwr(2'b01));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL sw cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
  endtask

  task automatic test_beq();
    item_t it;
    op = 7'b1100011; funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      push(1, 0, e_fetch(1, 2'b10));
      push(1, 0, e_dec(2'b10));
      push(1, 1'(z), e_beq(1'(z), 2'b10));
      for (int c = 0; sb.size() != 0; c++) begin
        it = sb.pop_front();
        @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
        n_chk++;
        if (obs !== it.e) begin
          n_fail++;
          $display("FAIL beq z%0d cyc%0d: got %h want %h", z, c, obs, it.e);
        end
      end
    end
    zero = 0;
  endtask

  task automatic test_jal();
    item_t it;
    op = 7'b1101111;
    push(1, 0, e_fetch(1, 2'b11));
    push(1, 1, e_dec(2'b11));
    push(1, 0, e_jal(2'b11));
    push(1, 1, e_aluwb(2'b11));
    push(0, 0, e_fetch(0, 2'b11));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL jal cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    item_t it;
    op = 7'b0100011;
    push(1, 0, e_fetch(1, 2'b01));
    push(0, 0, e_dec(2'b01));
    push(0, 0, e_memadr(2'b01));
    push(0, 0, e_memwr(2'b01));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL midwr cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
    // Raise reset between edges: the strobe must fall with no clock.
    #1 reset = 1; #1;
    n_chk++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL midwr_async: got mem_write=%b state=%0d want 0/0", mem_write, state);
    end
    @(negedge clk); mem_ready = 0; reset = 0;
  endtask

  task automatic test_trap();
    item_t it;
    op = 7'b1110011;
    push(1, 0, e_fetch(1, 2'b00));
    push(1, 0, e_dec(2'b00));
    for (int k = 0; k < 10; k++) push(1'(k), 1'(k >> 1), e_trap(2'b00));
    for (int c = 0; sb.size() != 0; c++) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      n_chk++;
      if (obs !== it.e) begin
        n_fail++;
        $display("FAIL trap cyc%0d: got %h want %h", c, obs, it.e);
      end
    end
    @(negedge clk); mem_ready = 1; reset = 1; #1;
    n_chk++;
    if (obs !== e_rst(2'b00)) begin
      n_fail++;
      $display("FAIL trap_reset: got %h want %h", obs, e_rst(2'b00));
    end
    @(negedge clk); mem_ready = 0; reset = 0;
    @(negedge clk); #1;
    n_chk++;
    if (obs !== e_fetch(0, 2'b00)) begin
      n_fail++;
      $display("FAIL trap_release: got %h want %h", obs, e_fetch(0, 2'b00));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_stall();
    test_sw();
    test_beq();
    test_jal();
    test_reset_midwrite();
    test_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
